// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register, valid/ready handshake + 2-entry skid.
// Full throughput; in_ready and out_data come straight from flops.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           squash every held beat (same effect as rst on the datapath)
//   in_valid/ready  upstream handshake, in_data upstream payload
//   out_valid/ready downstream handshake, out_data downstream payload
//   stall_cycles    cycles with out_valid & !out_ready      (PIPE_SKID_PERF_EN)
//   flush_count     flushes that squashed >=1 valid beat      (PIPE_SKID_PERF_EN)
//
// Define PIPE_SKID_PERF_EN to add the saturating perf counters (width CNT_W).

module pipe_skid_reg #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
`ifdef PIPE_SKID_PERF_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  logic             ov_n;
  logic             sv_n;
  logic [WIDTH-1:0] od_n;
  logic [WIDTH-1:0] sd_n;

  logic accept;
  logic deliver;
  logic st_empty;
  logic st_one;
  logic st_two;

  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;
  assign st_empty = !out_valid;
  assign st_one   = out_valid & !skid_valid;
  assign st_two   = out_valid & skid_valid;

  always_comb begin
    ov_n = out_valid;
    sv_n = skid_valid;
    od_n = out_data;
    sd_n = skid_data;
    unique case (1'b1)
      st_empty: begin
        if (accept) begin
          ov_n = 1'b1;
          od_n = in_data;
        end
      end
      st_one: begin
        if (accept && deliver) begin
          od_n = in_data;
        end else if (accept) begin
          sv_n = 1'b1;
          sd_n = in_data;
        end else if (deliver) begin
          ov_n = 1'b0;
        end
      end
      st_two: begin
        if (deliver) begin
          od_n = skid_data;
          sv_n = 1'b0;
        end
      end
      default: begin
        ov_n = out_valid;
      end
    endcase
  end

  // in_ready is its own flop, loaded with the inverse of next skid_valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= RESET_VALUE;
      skid_data  <= RESET_VALUE;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= ov_n;
      skid_valid <= sv_n;
      out_data   <= od_n;
      skid_data  <= sd_n;
      in_ready   <= !sv_n;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  // Counters saturate and survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush && (out_valid || skid_valid) && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vectors plus a queue-scoreboard random run
// for pipe_skid_reg (WIDTH=8, RESET_VALUE=8'h5A).

module tb_pipe_skid_reg;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'h5A;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef PIPE_SKID_PERF_EN
  logic [3:0]   stall_cycles;
  logic [3:0]   flush_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef PIPE_SKID_PERF_EN
  pipe_skid_reg #(
    .WIDTH(W),
    .RESET_VALUE(RV),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );
`else
  pipe_skid_reg #(
    .WIDTH(W),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );
`endif

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] q[$];
  logic [W-1:0] hold_d;
  logic         hold_v;
  logic [W-1:0] exp_d;
  logic [31:0]  st_save;

  initial begin
    // 1. reset then idle
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_ov", out_valid, 0);
    check_eq("rst_od", out_data, RV);
    check_eq("rst_rdy", in_ready, 1);
`ifdef PIPE_SKID_PERF_EN
    check_eq("rst_stall", stall_cycles, 0);
    check_eq("rst_flcnt", flush_count, 0);
`endif

    // 2. stream 1..8, one beat per cycle, 1-cycle lag
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
      check_eq($sformatf("str_ov%0d", i), out_valid, 1);
      check_eq($sformatf("str_od%0d", i), out_data, i);
      check_eq($sformatf("str_rdy%0d", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("str_drain", out_valid, 0);

    // 3. back-pressure fills skid, then release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    tick();
    check_eq("bp_a_od", out_data, 8'h0A);
    check_eq("bp_a_rdy", in_ready, 1);
    in_data = 8'h0B;
    tick();
    check_eq("bp_b_od", out_data, 8'h0A);
    check_eq("bp_b_rdy", in_ready, 0);
    in_data = 8'h0C;
    tick();
    check_eq("bp_hold_od", out_data, 8'h0A);
    check_eq("bp_hold_ov", out_valid, 1);
    check_eq("bp_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check_eq("rel_b", out_data, 8'h0B);
    check_eq("rel_b_rdy", in_ready, 1);
    tick();
    check_eq("rel_c", out_data, 8'h0C);
    check_eq("rel_c_ov", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check_eq("rel_end", out_valid, 0);

    // 4. flush from TWO with a beat offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    tick();
    in_data = 8'h0B;
    tick();
    check_eq("fl_pre_rdy", in_ready, 0);
`ifdef PIPE_SKID_PERF_EN
    st_save = 32'(stall_cycles);
`else
    st_save = 0;
`endif
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'h0D;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_ov", out_valid, 0);
    check_eq("fl_rdy", in_ready, 1);
    check_eq("fl_od", out_data, RV);
`ifdef PIPE_SKID_PERF_EN
    check_eq("fl_cnt", flush_count, 1);
    check_eq("fl_stall", stall_cycles, st_save);
`endif
    tick();
    check_eq("fl_drop", out_valid, 0);
    // flush with nothing held does not count
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef PIPE_SKID_PERF_EN
    check_eq("fl_empty_cnt", flush_count, 1);
`endif
    check_eq("fl_empty_ov", out_valid, 0);

    // flush with in_ready=1 in EMPTY still drops the beat
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("fl_rdy_drop", out_valid, 0);

    // reset mid-operation from ONE with a beat offered
    in_valid = 1'b1;
    in_data  = 8'h44;
    out_ready = 1'b0;
    tick();
    check_eq("mr_ld", out_valid, 1);
    rst     = 1'b1;
    in_data = 8'h45;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("mr_ov", out_valid, 0);
    check_eq("mr_od", out_data, RV);
    check_eq("mr_rdy", in_ready, 1);
`ifdef PIPE_SKID_PERF_EN
    check_eq("mr_flcnt", flush_count, 0);
    check_eq("mr_stall", stall_cycles, 0);
`endif

    // 5. random handshakes against a queue scoreboard
    hold_v = 1'b0;
    hold_d = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check_eq("rnd_ov", out_valid, q.size() > 0);
      check_eq("rnd_rdy", in_ready, q.size() < 2);
      if (hold_v) begin
        check_eq("rnd_stable_v", out_valid, 1);
        check_eq("rnd_stable_d", out_data, hold_d);
      end
      if (!in_valid || in_ready) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        exp_d = (q.size() > 0) ? q.pop_front() : ~out_data;
        check_eq("rnd_data", out_data, exp_d);
      end
      if (in_valid && in_ready) q.push_back(in_data);
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        exp_d = (q.size() > 0) ? q.pop_front() : ~out_data;
        check_eq("drain_data", out_data, exp_d);
      end
      @(negedge clk);
    end
    check_eq("drain_empty", out_valid, 0);
    check_eq("drain_q", q.size(), 0);

`ifdef PIPE_SKID_PERF_EN
    // 6. stall counter saturates at 15 with CNT_W=4
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    in_valid = 1'b0;
    check_eq("sat_0", stall_cycles, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_eq($sformatf("sat_%0d", i), stall_cycles, (i > 15) ? 15 : i);
    end
    check_eq("sat_od", out_data, 8'h77);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
